can_rx_frame: RTL and testbench

CAN 2.0A receive frame engine: consumes sampled bus bits from the bit-timing stage and removes stuff bits. It parses standard (11-bit ID) data/remote frames and checks the 15-bit CRC (polynomial 0x4599, init 0). Results are presented to the controller register interface with error pulses. This block is the receive-side counterpart of the transmit CRC/serializer path.

---
 rtl/can_rx_frame_if.sv | 36 +++
 rtl/can_rx_frame.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_can_rx_frame.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_rx_frame_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : can_rx_frame_if                                         |
// | Brief    : Sampled-bit input and frame result bundle of the CAN    |
// |            2.0A receive frame engine.                              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface can_rx_frame_if;
  logic        bit_valid;
  logic        rx_bit;
  logic        frame_valid;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        err_stuff;
  logic        err_form;
  logic        err_crc;
  logic        busy;
  logic        ack_drive;

  // Bit-timing stage / controller side.
  modport master (
    output bit_valid, rx_bit,
    input  frame_valid, rx_id, rx_rtr, rx_dlc, rx_data,
    input  err_stuff, err_form, err_crc, busy, ack_drive
  );

  // Frame engine side.
  modport slave (
    input  bit_valid, rx_bit,
    output frame_valid, rx_id, rx_rtr, rx_dlc, rx_data,
    output err_stuff, err_form, err_crc, busy, ack_drive
  );
endinterface
`default_nettype wire

// File: rtl/can_rx_frame.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : can_rx_frame                                            |
// | Brief    : CAN 2.0A receive frame engine. Destuffs sampled bits,   |
// |            parses standard data/remote frames, checks CRC-15 and   |
// |            reports the frame or a single error pulse.              |
// |            Optional macro CAN_RX_ACK_EN enables ack_drive.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module can_rx_frame (
  input  logic            clk,
  input  logic            rst,
  can_rx_frame_if.slave   bus
);

  typedef enum logic [3:0] {
    S_INTEG   = 4'd0,
    S_IDLE    = 4'd1,
    S_ARB     = 4'd2,
    S_CTRL    = 4'd3,
    S_DATA    = 4'd4,
    S_CRC     = 4'd5,
    S_CRC_DEL = 4'd6,
    S_ACK     = 4'd7,
    S_ACK_DEL = 4'd8,
    S_EOF     = 4'd9
  } state_t;

  localparam logic [14:0] CRC_POLY = 15'h4599;

  // One CRC-15 step for a destuffed bit.
  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    if (b ^ c[14]) crc_step = {c[13:0], 1'b0} ^ CRC_POLY;
    else           crc_step = {c[13:0], 1'b0};
  endfunction

  state_t      state, state_nxt;
  logic [6:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]  run_cnt, run_cnt_nxt;
  logic        last_bit, last_bit_nxt;
  logic [14:0] crc, crc_nxt;
  logic [13:0] crc_rx, crc_rx_nxt;     // first 14 received CRC bits
  logic        crc_ok, crc_ok_nxt;
  logic [10:0] id_sh, id_sh_nxt;
  logic        rtr_sh, rtr_sh_nxt;
  logic [3:0]  dlc_sh, dlc_sh_nxt;
  logic [63:0] data_sh, data_sh_nxt;

  logic        frame_valid_r, frame_valid_nxt;
  logic [10:0] rx_id_r, rx_id_nxt;
  logic        rx_rtr_r, rx_rtr_nxt;
  logic [3:0]  rx_dlc_r, rx_dlc_nxt;
  logic [63:0] rx_data_r, rx_data_nxt;
  logic        err_stuff_r, err_stuff_nxt;
  logic        err_form_r, err_form_nxt;
  logic        err_crc_r, err_crc_nxt;
  logic        busy_r, busy_nxt;

  logic        stuff_slot;
  logic        abort;
  logic [3:0]  dlc_new;
  logic [6:0]  data_bits;

  // Payload length in bits: DLC values above 8 still carry 8 bytes.
  assign data_bits = (dlc_sh > 4'd8) ? 7'd64 : {dlc_sh, 3'b000};

  // Register the whole engine state and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_INTEG;
      bit_cnt       <= '0;
      run_cnt       <= '0;
      last_bit      <= 1'b0;
      crc           <= '0;
      crc_rx        <= '0;
      crc_ok        <= 1'b0;
      id_sh         <= '0;
      rtr_sh        <= 1'b0;
      dlc_sh        <= '0;
      data_sh       <= '0;
      frame_valid_r <= 1'b0;
      rx_id_r       <= '0;
      rx_rtr_r      <= 1'b0;
      rx_dlc_r      <= '0;
      rx_data_r     <= '0;
      err_stuff_r   <= 1'b0;
      err_form_r    <= 1'b0;
      err_crc_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      run_cnt       <= run_cnt_nxt;
      last_bit      <= last_bit_nxt;
      crc           <= crc_nxt;
      crc_rx        <= crc_rx_nxt;
      crc_ok        <= crc_ok_nxt;
      id_sh         <= id_sh_nxt;
      rtr_sh        <= rtr_sh_nxt;
      dlc_sh        <= dlc_sh_nxt;
      data_sh       <= data_sh_nxt;
      frame_valid_r <= frame_valid_nxt;
      rx_id_r       <= rx_id_nxt;
      rx_rtr_r      <= rx_rtr_nxt;
      rx_dlc_r      <= rx_dlc_nxt;
      rx_data_r     <= rx_data_nxt;
      err_stuff_r   <= err_stuff_nxt;
      err_form_r    <= err_form_nxt;
      err_crc_r     <= err_crc_nxt;
      busy_r        <= busy_nxt;
    end
  end

  // Destuffing, field parsing and next-state decode for each sampled bit.
  always_comb begin
    state_nxt       = state;
    bit_cnt_nxt     = bit_cnt;
    run_cnt_nxt     = run_cnt;
    last_bit_nxt    = last_bit;
    crc_nxt         = crc;
    crc_rx_nxt      = crc_rx;
    crc_ok_nxt      = crc_ok;
    id_sh_nxt       = id_sh;
    rtr_sh_nxt      = rtr_sh;
    dlc_sh_nxt      = dlc_sh;
    data_sh_nxt     = data_sh;
    frame_valid_nxt = 1'b0;
    rx_id_nxt       = rx_id_r;
    rx_rtr_nxt      = rx_rtr_r;
    rx_dlc_nxt      = rx_dlc_r;
    rx_data_nxt     = rx_data_r;
    err_stuff_nxt   = 1'b0;
    err_form_nxt    = 1'b0;
    err_crc_nxt     = 1'b0;
    busy_nxt        = busy_r;
    stuff_slot      = 1'b0;
    abort           = 1'b0;
    dlc_new         = {dlc_sh[2:0], bus.rx_bit};

    // Stuff handling: CRC_DEL only sees the stuff bit that may follow
    // the last CRC bit; its own delimiter bit is never counted.
    if (bus.bit_valid && (state inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL})) begin
      if (run_cnt == 3'd5) begin
        stuff_slot = 1'b1;
        if (bus.rx_bit == last_bit) begin
          err_stuff_nxt = 1'b1;
          abort         = 1'b1;
        end else begin
          run_cnt_nxt  = 3'd1;
          last_bit_nxt = bus.rx_bit;
        end
      end else if (state != S_CRC_DEL) begin
        run_cnt_nxt  = (bus.rx_bit == last_bit) ? run_cnt + 3'd1 : 3'd1;
        last_bit_nxt = bus.rx_bit;
      end
    end

    if (bus.bit_valid && !stuff_slot) begin
      unique case (state)
        S_INTEG: begin
          if (bus.rx_bit) begin
            if (bit_cnt == 7'd10) begin
              state_nxt   = S_IDLE;
              bit_cnt_nxt = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + 7'd1;
            end
          end else begin
            bit_cnt_nxt = '0;
          end
        end
        S_IDLE: begin
          if (!bus.rx_bit) begin
            state_nxt    = S_ARB;
            bit_cnt_nxt  = '0;
            run_cnt_nxt  = 3'd1;
            last_bit_nxt = 1'b0;
            crc_nxt      = crc_step(15'd0, 1'b0);
            crc_rx_nxt   = '0;
            crc_ok_nxt   = 1'b0;
            id_sh_nxt    = '0;
            rtr_sh_nxt   = 1'b0;
            dlc_sh_nxt   = '0;
            data_sh_nxt  = '0;
            busy_nxt     = 1'b1;
          end
        end
        S_ARB: begin
          crc_nxt = crc_step(crc, bus.rx_bit);
          if (bit_cnt < 7'd11) begin
            id_sh_nxt   = {id_sh[9:0], bus.rx_bit};
            bit_cnt_nxt = bit_cnt + 7'd1;
          end else begin
            rtr_sh_nxt  = bus.rx_bit;
            state_nxt   = S_CTRL;
            bit_cnt_nxt = '0;
          end
        end
        S_CTRL: begin
          crc_nxt = crc_step(crc, bus.rx_bit);
          if (bit_cnt == 7'd0 && bus.rx_bit) begin
            err_form_nxt = 1'b1;          // extended frames are not accepted
            abort        = 1'b1;
          end else if (bit_cnt >= 7'd2) begin
            dlc_sh_nxt = dlc_new;
            if (bit_cnt == 7'd5) begin
              bit_cnt_nxt = '0;
              state_nxt   = (rtr_sh || dlc_new == 4'd0) ? S_CRC : S_DATA;
            end else begin
              bit_cnt_nxt = bit_cnt + 7'd1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 7'd1;
          end
        end
        S_DATA: begin
          crc_nxt = crc_step(crc, bus.rx_bit);
          data_sh_nxt[~bit_cnt[5:0]] = bus.rx_bit;   // bit 63 first
          if (bit_cnt == data_bits - 7'd1) begin
            state_nxt   = S_CRC;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 7'd1;
          end
        end
        S_CRC: begin
          crc_rx_nxt = {crc_rx[12:0], bus.rx_bit};
          if (bit_cnt == 7'd14) begin
            crc_ok_nxt  = ({crc_rx, bus.rx_bit} == crc);
            state_nxt   = S_CRC_DEL;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 7'd1;
          end
        end
        S_CRC_DEL: begin
          if (!bus.rx_bit) begin
            err_form_nxt = 1'b1;
            abort        = 1'b1;
          end else begin
            state_nxt = S_ACK;
          end
        end
        S_ACK: begin
          state_nxt = S_ACK_DEL;
        end
        S_ACK_DEL: begin
          if (!bus.rx_bit) begin
            err_form_nxt = 1'b1;          // form error wins over CRC error
            abort        = 1'b1;
          end else if (!crc_ok) begin
            err_crc_nxt = 1'b1;
            abort       = 1'b1;
          end else begin
            state_nxt   = S_EOF;
            bit_cnt_nxt = '0;
          end
        end
        S_EOF: begin
          if (!bus.rx_bit) begin
            err_form_nxt = 1'b1;
            abort        = 1'b1;
          end else if (bit_cnt == 7'd6) begin
            frame_valid_nxt = 1'b1;
            rx_id_nxt       = id_sh;
            rx_rtr_nxt      = rtr_sh;
            rx_dlc_nxt      = dlc_sh;
            rx_data_nxt     = data_sh;
            busy_nxt        = 1'b0;
            state_nxt       = S_IDLE;
            bit_cnt_nxt     = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 7'd1;
          end
        end
        default: begin
          state_nxt   = S_INTEG;
          bit_cnt_nxt = '0;
        end
      endcase
    end

    // Any error discards the frame and re-integrates to the bus.
    if (abort) begin
      state_nxt   = S_INTEG;
      bit_cnt_nxt = '0;
      busy_nxt    = 1'b0;
    end
  end

`ifdef CAN_RX_ACK_EN
  logic ack_drive_r;

  // Request a dominant ACK for exactly the ACK slot of a clean frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_drive_r <= 1'b0;
    end else if (bus.bit_valid && state == S_CRC_DEL && run_cnt != 3'd5) begin
      ack_drive_r <= bus.rx_bit && crc_ok;
    end else if (bus.bit_valid && state == S_ACK) begin
      ack_drive_r <= 1'b0;
    end
  end

  assign bus.ack_drive = ack_drive_r;
`else
  assign bus.ack_drive = 1'b0;
`endif

  assign bus.frame_valid = frame_valid_r;
  assign bus.rx_id       = rx_id_r;
  assign bus.rx_rtr      = rx_rtr_r;
  assign bus.rx_dlc      = rx_dlc_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.err_stuff   = err_stuff_r;
  assign bus.err_form    = err_form_r;
  assign bus.err_crc     = err_crc_r;
  assign bus.busy        = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_frame.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_can_rx_frame                                         |
// | Brief    : Scoreboard bench for can_rx_frame: builds stuffed CAN   |
// |            frames, predicts each result pulse and its position.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_can_rx_frame;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_STUFF = 2;
  localparam int K_FORM  = 4;
  localparam int K_CRC   = 8;

`ifdef CAN_RX_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef struct {
    int          kind;
    int          idx;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  can_rx_frame_if bus();

  can_rx_frame dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  exp_t sb[$];
  int   drv_cnt = 0;
  int   cap_cnt = 0;
  logic bv_d    = 1'b0;
  logic mon_en  = 1'b0;
  int   ack_lo  = 0;
  int   ack_hi  = 0;

  logic [10:0] last_id   = '0;
  logic        last_rtr  = 1'b0;
  logic [3:0]  last_dlc  = '0;
  logic [63:0] last_data = '0;

  // Frame under construction.
  logic        fb[$];
  logic [10:0] bld_id;
  logic        bld_rtr;
  logic [3:0]  bld_dlc;
  logic [63:0] bld_data;
  int ix_ide, ix_data0, ix_crcdel, ix_ack, ix_ackdel, ix_eoflast;

  // Count strobes on the same edge the DUT samples them.
  always @(posedge clk) begin
    if (bus.bit_valid) cap_cnt <= cap_cnt + 1;
    bv_d <= bus.bit_valid;
  end

  logic [3:0] pv;
  exp_t       me;
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("ack_drive", {63'd0, bus.ack_drive},
                {63'd0, (cap_cnt >= ack_lo && cap_cnt < ack_hi)});
      pv = {bus.err_crc, bus.err_form, bus.err_stuff, bus.frame_valid};
      if (pv != 4'd0) begin
        if (sb.size() == 0) begin
          check_val("unexpected_pulse", {60'd0, pv}, 64'd0);
        end else begin
          me = sb.pop_front();
          check_val("pulse_kind", {60'd0, pv}, me.kind);
          check_val("pulse_pos", bv_d ? cap_cnt : -1, me.idx);
          check_val("rx_id", {53'd0, bus.rx_id}, {53'd0, me.id});
          check_val("rx_rtr", {63'd0, bus.rx_rtr}, {63'd0, me.rtr});
          check_val("rx_dlc", {60'd0, bus.rx_dlc}, {60'd0, me.dlc});
          check_val("rx_data", bus.rx_data, me.data);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    int gap;
    gap = ($urandom_range(3) == 0) ? 1 : 0;
    repeat (gap) begin
      @(posedge clk); #1;
      bus.bit_valid = 1'b0;
      bus.rx_bit    = ~b;              // must be ignored
    end
    @(posedge clk); #1;
    bus.bit_valid = 1'b1;
    bus.rx_bit    = b;
    drv_cnt++;
  endtask

  // Build a stuffed frame; positions recorded are indices into fb.
  task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                       input logic [63:0] data, input logic ide, input logic crc_flip,
                       input logic crcdel_dom);
    logic        raw[$];
    logic [14:0] c;
    int          nbits, run;
    logic        last;
    raw.delete();
    bld_id = id; bld_rtr = rtr; bld_dlc = dlc; bld_data = '0;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nbits = rtr ? 0 : ((dlc > 8) ? 64 : dlc * 8);
    for (int k = 0; k < nbits; k++) begin
      raw.push_back(data[63-k]);
      bld_data[63-k] = data[63-k];
    end
    c = '0;
    foreach (raw[i]) begin
      if (raw[i] ^ c[14]) c = {c[13:0], 1'b0} ^ 15'h4599;
      else                c = {c[13:0], 1'b0};
    end
    if (crc_flip) c[0] = ~c[0];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    fb.delete();
    run = 0; last = 1'b0; ix_data0 = 0;
    foreach (raw[i]) begin
      fb.push_back(raw[i]);
      if (i == 13) ix_ide = fb.size() - 1;
      if (i == 19) ix_data0 = fb.size() - 1;
      if (i == 0 || raw[i] != last) run = 1;
      else run++;
      last = raw[i];
      if (run == 5) begin
        fb.push_back(~last);
        last = ~last;
        run  = 1;
      end
    end
    ix_crcdel = fb.size(); fb.push_back(~crcdel_dom);
    ix_ack    = fb.size(); fb.push_back(1'b0);
    ix_ackdel = fb.size(); fb.push_back(1'b1);
    for (int i = 0; i < 7; i++) fb.push_back(1'b1);
    ix_eoflast = fb.size() - 1;
  endtask

  // Queue the predicted outcome, then drive the frame and idle bits.
  task automatic send_frame(input int kind, input int pos, input logic ack, input int idle_n);
    exp_t e;
    int   base;
    base = drv_cnt;
    if (kind == K_VALID) begin
      last_id = bld_id; last_rtr = bld_rtr; last_dlc = bld_dlc; last_data = bld_data;
    end
    if (kind != K_NONE) begin
      e.kind = kind; e.idx = base + pos + 1;
      e.id = last_id; e.rtr = last_rtr; e.dlc = last_dlc; e.data = last_data;
      sb.push_back(e);
    end
    if (ack && ACK_EN) begin
      ack_lo = base + ix_crcdel + 1;
      ack_hi = base + ix_ack + 1;
    end else begin
      ack_lo = 0; ack_hi = 0;
    end
    foreach (fb[i]) drive_bit(fb[i]);
    repeat (idle_n) drive_bit(1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rid;
    logic [3:0]  rdlc;
    bus.bit_valid = 1'b0;
    bus.rx_bit    = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs",
              {52'd0, bus.frame_valid, bus.err_stuff, bus.err_form, bus.err_crc,
               bus.busy, bus.ack_drive, bus.rx_rtr, bus.rx_dlc, 1'b0}, 64'd0);
    check_val("reset_rx_id", {53'd0, bus.rx_id}, 64'd0);
    check_val("reset_rx_data", bus.rx_data, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (11) drive_bit(1'b1);

    // Basic data frame.
    build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    send_frame(K_VALID, ix_eoflast, 1'b1, 11);

    // Six dominant bits: stuff error, then a frame too early to be seen.
    fb.delete();
    repeat (6) fb.push_back(1'b0);
    send_frame(K_STUFF, 5, 1'b0, 4);
    build(11'h055, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    send_frame(K_NONE, 0, 1'b0, 11);
    build(11'h2AA, 1'b0, 4'd1, 64'hC300_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    send_frame(K_VALID, ix_eoflast, 1'b1, 11);

    // Corrupted CRC LSB.
    build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    send_frame(K_CRC, ix_ackdel, 1'b0, 11);

    // Dominant CRC delimiter, then recessive IDE.
    build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    send_frame(K_FORM, ix_crcdel, 1'b0, 11);
    build(11'h321, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 1'b1, 1'b0, 1'b0);
    send_frame(K_FORM, ix_ide, 1'b0, 11);

    // Remote frame with all-recessive ID.
    build(11'h7FF, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 1'b0);
    send_frame(K_VALID, ix_eoflast, 1'b1, 11);

    // DLC boundaries: 8 and 15 (both carry 8 bytes), 0.
    build(11'h000, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0);
    send_frame(K_VALID, ix_eoflast, 1'b1, 11);
    build(11'h5A5, 1'b0, 4'd15, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b0);
    send_frame(K_VALID, ix_eoflast, 1'b1, 11);
    build(11'h0F0, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send_frame(K_VALID, ix_eoflast, 1'b1, 11);

    // Random frames.
    for (int n = 0; n < 4; n++) begin
      rid  = 11'($urandom);
      rdlc = 4'($urandom);
      build(rid, 1'($urandom), rdlc, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      send_frame(K_VALID, ix_eoflast, 1'b1, 11);
    end

    // Reset in the middle of the data field.
    build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    ack_lo = 0; ack_hi = 0;
    for (int i = 0; i <= ix_data0 + 3; i++) drive_bit(fb[i]);
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    @(negedge clk);
    check_val("busy_mid_frame", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_val("busy_after_rst", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_id = '0; last_rtr = 1'b0; last_dlc = '0; last_data = '0;
    repeat (11) drive_bit(1'b1);
    build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    send_frame(K_VALID, ix_eoflast, 1'b1, 11);

    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    repeat (4) @(posedge clk);
    check_val("scoreboard_drained", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
